// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with an input synchroniser.
// It checks odd parity and the stop bit, runs a frame watchdog, and
// buffers good frames in a first-word-fall-through FIFO so software
// can drain several scan codes per poll.
//
// Build option: PS2_RX_PARITY_EN
//   defined   -> odd parity is enforced; frames with bad parity are
//                dropped and reported on parity_err.
//   undefined -> the parity bit is shifted in but ignored; parity_err
//                stays 0 and any frame with stop=1 is pushed.
module ps2_rx_fifo #(
    parameter int DATA_W         = 8,
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clk_ps2,
    input  logic                              bus_in,
    input  logic                              rd_en,
    output logic [DATA_W-1:0]                 bus_out,
    output logic                              valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
    output logic                              parity_err,
    output logic                              frame_err,
    output logic                              overflow
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronisers and falling-edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;
    logic                   ps2_clk_s;
    logic                   ps2_dat_s;
    logic                   fe;

    assign ps2_clk_s = clk_sync[SYNC_STAGES-1];
    assign ps2_dat_s = dat_sync[SYNC_STAGES-1];
    assign fe        = clk_prev & ~ps2_clk_s;

    // Shift both pins through the synchroniser chain; idle bus level is 1.
    // NOTE: every register below is assigned with <= so all flops sample
    // the pre-edge values; a blocking = here would collapse the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], clk_ps2};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], bus_in};
            clk_prev <= ps2_clk_s;
        end
    end

    // ------------------------------------------------------------------
    // Frame receiver FSM with watchdog
    // ------------------------------------------------------------------
    state_t              state;
    logic [BIT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   shift_reg;
    logic [WD_W-1:0]     wd_cnt;
    logic                push_req;
    logic [DATA_W-1:0]   push_data;
    logic                parity_ok;

`ifdef PS2_RX_PARITY_EN
    logic                par_bit;
    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    assign parity_ok = ^{shift_reg, par_bit};
`else
    assign parity_ok = 1'b1;
`endif

    // Walk start/data/parity/stop on each PS/2 falling edge; the watchdog
    // aborts a frame whose clock stalls, and a completed frame either
    // raises one error pulse or requests a FIFO push.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            wd_cnt     <= '0;
            push_req   <= 1'b0;
            push_data  <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
`ifdef PS2_RX_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            push_req   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;

            if (state == S_IDLE || fe) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end

            if (fe) begin
                case (state)
                    S_IDLE: begin
                        if (!ps2_dat_s) begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    S_DATA: begin
                        // LSB arrives first, so shifting right leaves bit 0
                        // in position 0 after DATA_W samples.
                        shift_reg <= {ps2_dat_s, shift_reg[DATA_W-1:1]};
                        if (bit_cnt == BIT_LAST) begin
                            state <= S_PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    S_PARITY: begin
`ifdef PS2_RX_PARITY_EN
                        par_bit <= ps2_dat_s;
`endif
                        state <= S_STOP;
                    end
                    S_STOP: begin
                        state <= S_IDLE;
                        if (!parity_ok) begin
                            parity_err <= 1'b1;
                        end else if (!ps2_dat_s) begin
                            frame_err <= 1'b1;
                        end else begin
                            push_req  <= 1'b1;
                            push_data <= shift_reg;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (state != S_IDLE && wd_cnt == WD_LAST) begin
                frame_err <= 1'b1;
                state     <= S_IDLE;
            end
        end
    end

    // ------------------------------------------------------------------
    // First-word-fall-through FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt_q;
    logic              full;
    logic              pop;
    logic              wr_ok;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Decide this cycle's pop and write; a pop frees a slot for a same-cycle
    // push, so a full FIFO still accepts the frame when it is being read.
    // NOTE: each output gets a default on entry so no path can leave it
    // unassigned, which is what keeps this block free of latches.
    always_comb begin
        full  = 1'b0;
        pop   = 1'b0;
        wr_ok = 1'b0;
        full  = (cnt_q == CNT_FULL);
        pop   = rd_en && (cnt_q != '0);
        wr_ok = push_req && (!full || pop);
    end

    // Storage array is written only on accepted pushes.
    // NOTE: the data array is deliberately not reset; the pointers and count
    // define which entries are meaningful, and bus_out masks stale contents.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Advance pointers, track occupancy and flag frames lost to a full FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt_q    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push_req && full && !pop;
            if (wr_ok) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({wr_ok, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign valid   = (cnt_q != '0);
    assign count   = cnt_q;
    assign bus_out = valid ? mem[rd_ptr] : '0;

endmodule
